pulse_rx_monitor: RTL and testbench
===================================

// Module: pulse_rx_monitor
// PURPOSE
//  Receive-side monitor for the pulse interface driven by the pulse controller (pulse_active/out_val).
//  Detects each pulse, measures its length and amplitude, flags protocol errors, and
//  buffers one result record per pulse in a FIFO read out over a valid/ready handshake.
//  Sits between the pulse drive path and the measurement/readout logic of the simulator.
// PARAMETERS
//  AW       8   amplitude width (matches out_val)
//  LW       4   pulse-length counter width; saturates at 2**LW-1
//  EXP_LEN  4   expected pulse length in cycles (controller drives 4)
//  DEPTH    4   result FIFO depth, power of two, >=2
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      async active-low reset
//  pulse_in     in   1      pulse active (same clock domain, no synchroniser)
//  amp_in       in   AW     pulse amplitude
//  res_valid    out  1      FIFO head record valid
//  res_ready    in   1      consumer accepts head record
//  res_amp      out  AW     amplitude captured on first pulse cycle
//  res_len      out  LW     pulse length in cycles (saturated)
//  res_len_err  out  1      res_len != EXP_LEN, or length saturated
//  res_amp_err  out  1      amp_in changed during pulse
//  res_state    out  1      discriminated qubit state (see CONFIGURATION)
//  overflow     out  1      sticky: a record was dropped on full FIFO
//  glitch       out  1      sticky: amp_in != 0 while pulse_in low and idle
//  drop_cnt     out  8      dropped-record count, saturates at 255
// BEHAVIOUR
//  - Reset: FIFO empty, res_valid=0, all res_* = 0, overflow=0, glitch=0, drop_cnt=0, FSM IDLE,
//    prev_pulse=1 (a pulse already high at reset release is ignored until pulse_in falls).
//  - FSM IDLE: pulse_in=1 & prev_pulse=0 -> MEAS; capture amp=amp_in, len=1, amp_err=0.
//  - FSM MEAS: pulse_in=1 -> len+1 (saturate at 2**LW-1, set sat flag); amp_in!=amp -> amp_err=1.
//    pulse_in=0 -> build record, push to FIFO, -> IDLE. Same-cycle rising edge impossible (needs prev=0).
//  - Latency: falling edge sampled at edge N -> push at N; if FIFO was empty res_valid=1 after N.
//  - res_len_err = (len != EXP_LEN) | sat. Record fields are registered, stable while res_valid & !res_ready.
//  - Pop on res_valid & res_ready; next record presented next cycle (first-word-fall-through).
//  - Full: push without same-cycle pop -> record dropped, overflow<=1, drop_cnt+1 (sat 255).
//    Full with same-cycle pop -> push accepted, no drop. Empty: res_ready ignored.
//  - glitch set when FSM IDLE, pulse_in=0, amp_in!=0; cleared only by reset.
//  - Reset mid-pulse: partial measurement and FIFO contents discarded, no record emitted.
// CONFIGURATION
//  - Macro PULSE_RX_THRESH_EN: adds input port thresh [AW]; res_state = (res_amp >= thresh),
//    evaluated at push time and stored in the record.
//  - Without macro: no thresh port; res_state constant 0, stored bit removed by synthesis.
// STRUCTURE
//  - Package pulse_rx_pkg: typedef struct packed pulse_rec_t {amp, len, len_err, amp_err, state};
//    typedef enum {RX_IDLE, RX_MEAS} rx_state_e; localparam DROP_MAX=8'hFF.
//  - Sub-module pulse_rx_fifo: generic sync FIFO of pulse_rec_t, DEPTH entries, FWFT,
//    ptr+1 extra bit for full/empty, push/pop/full/empty ports.
//  - Top: edge detect, FSM, counters, record build, sticky flags.
// TESTING
//  - amp=0x5A held 4 cycles -> one record amp=0x5A len=4 len_err=0 amp_err=0, res_valid 1 cycle after fall.
//  - pulse 6 cycles, amp 0x10 then 0x20 at cycle 3 -> amp=0x10 len=6 len_err=1 amp_err=1.
//  - 20-cycle pulse, LW=4 -> len=15 len_err=1; 5 pulses with res_ready=0, DEPTH=4 ->
//    4 records kept in order, overflow=1, drop_cnt=1.
//  - FIFO full, push and pop same cycle -> no drop, drop_cnt unchanged, order preserved.
//  - rst_n low at pulse cycle 2, release while pulse_in=1 -> no record; next clean pulse measured.
//  - PULSE_RX_THRESH_EN, thresh=0x80: amp 0x7F -> state 0, amp 0x80 -> state 1; amp_in=0x03
//    while idle -> glitch=1.

Source files
------------

// File: rtl/pulse_rx_pkg.sv
// Shared types for the pulse receive monitor: record layout, FSM encoding, drop-count limit.
// Record field widths here fix the AW/LW seen by pulse_rx_monitor.
package pulse_rx_pkg;

  localparam int         REC_AW   = 8;
  localparam int         REC_LW   = 4;
  localparam logic [7:0] DROP_MAX = 8'hFF;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_MEAS = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic [REC_AW-1:0] amp;
    logic [REC_LW-1:0] len;
    logic              len_err;
    logic              amp_err;
    logic              state;
  } pulse_rec_t;

endpackage

// File: rtl/pulse_rx_fifo.sv
// First-word-fall-through synchronous FIFO of pulse records, DEPTH a power of two >= 2.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module pulse_rx_fifo
  import pulse_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  pulse_rec_t din,
  output logic       full,
  input  logic       pop,
  output pulse_rec_t dout,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic        wr_en;
  logic        rd_en;
  pulse_rec_t  mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  // Head is forced to zero when empty so the unreset storage never reaches the outputs.
  assign dout = empty ? '0 : mem[rd_ptr[PW-1:0]];

  // NOTE: non-blocking assignments for all sequential state so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; validity comes from the pointers alone.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/pulse_rx_monitor.sv
// Pulse receive monitor: measures length/amplitude of each pulse and queues one record per pulse.
// Optional macro PULSE_RX_THRESH_EN adds a thresh port and amplitude-threshold state discrimination.
module pulse_rx_monitor
  import pulse_rx_pkg::*;
#(
  parameter int AW      = REC_AW,
  parameter int LW      = REC_LW,
  parameter int EXP_LEN = 4,
  parameter int DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pulse_in,
  input  logic [AW-1:0] amp_in,
`ifdef PULSE_RX_THRESH_EN
  input  logic [AW-1:0] thresh,
`endif
  output logic          res_valid,
  input  logic          res_ready,
  output logic [AW-1:0] res_amp,
  output logic [LW-1:0] res_len,
  output logic          res_len_err,
  output logic          res_amp_err,
  output logic          res_state,
  output logic          overflow,
  output logic          glitch,
  output logic [7:0]    drop_cnt
);

  localparam logic          S_IDLE  = RX_IDLE;
  localparam logic          S_MEAS  = RX_MEAS;
  localparam logic [LW-1:0] LEN_MAX = '1;

  logic          state;
  logic          prev_pulse;
  logic [AW-1:0] amp_q;
  logic [LW-1:0] len_q;
  logic          sat_q;
  logic          amp_err_q;
  logic          rec_state;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  pulse_rec_t    rec_in;
  pulse_rec_t    rec_out;

`ifdef PULSE_RX_THRESH_EN
  assign rec_state = (amp_q >= thresh);
`else
  assign rec_state = 1'b0;
`endif

  // Record is built from the measurement registers in the cycle the falling edge is sampled.
  assign push           = (state == S_MEAS) && !pulse_in;
  assign pop            = res_valid & res_ready;
  assign rec_in.amp     = amp_q;
  assign rec_in.len     = len_q;
  assign rec_in.len_err = (len_q != LW'(EXP_LEN)) | sat_q;
  assign rec_in.amp_err = amp_err_q;
  assign rec_in.state   = rec_state;

  // prev_pulse resets high so a pulse already active at reset release is not measured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      prev_pulse <= 1'b1;
      amp_q      <= '0;
      len_q      <= '0;
      sat_q      <= 1'b0;
      amp_err_q  <= 1'b0;
    end else begin
      prev_pulse <= pulse_in;
      case (state)
        S_IDLE: begin
          if (pulse_in && !prev_pulse) begin
            state     <= S_MEAS;
            amp_q     <= amp_in;
            len_q     <= LW'(1);
            sat_q     <= 1'b0;
            amp_err_q <= 1'b0;
          end
        end
        S_MEAS: begin
          if (pulse_in) begin
            if (len_q == LEN_MAX) sat_q <= 1'b1;
            else                  len_q <= len_q + 1'b1;
            if (amp_in != amp_q) amp_err_q <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      glitch   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push && full && !pop) begin
        overflow <= 1'b1;
        if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 1'b1;
      end
      if ((state == S_IDLE) && !pulse_in && (amp_in != '0)) glitch <= 1'b1;
    end
  end

  pulse_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (rec_in),
    .full  (full),
    .pop   (pop),
    .dout  (rec_out),
    .empty (empty)
  );

  assign res_valid   = ~empty;
  assign res_amp     = rec_out.amp;
  assign res_len     = rec_out.len;
  assign res_len_err = rec_out.len_err;
  assign res_amp_err = rec_out.amp_err;
  assign res_state   = rec_out.state;

endmodule

// File: tb/tb_pulse_rx_monitor.sv
// Directed self-checking bench for pulse_rx_monitor (default parameters).
// Define PULSE_RX_THRESH_EN for both files to exercise the threshold feature.
module tb_pulse_rx_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pulse_in;
  logic [7:0] amp_in;
  logic [7:0] thresh;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_amp;
  logic [3:0] res_len;
  logic       res_len_err;
  logic       res_amp_err;
  logic       res_state;
  logic       overflow;
  logic       glitch;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pulse_rx_monitor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pulse_in    (pulse_in),
    .amp_in      (amp_in),
`ifdef PULSE_RX_THRESH_EN
    .thresh      (thresh),
`endif
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_amp     (res_amp),
    .res_len     (res_len),
    .res_len_err (res_len_err),
    .res_amp_err (res_amp_err),
    .res_state   (res_state),
    .overflow    (overflow),
    .glitch      (glitch),
    .drop_cnt    (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts at a falling clock edge; holds the pulse for len cycles, amplitude switches to a1
  // from cycle chg (0 = never), then drops the pulse and waits one cycle so the record is pushed.
  task automatic send_pulse(input int len, input logic [7:0] a0, input logic [7:0] a1,
                            input int chg, input logic pop_at_fall);
    for (int i = 1; i <= len; i++) begin
      pulse_in = 1'b1;
      amp_in   = (chg != 0 && i >= chg) ? a1 : a0;
      @(negedge clk);
    end
    pulse_in  = 1'b0;
    amp_in    = 8'h00;
    res_ready = pop_at_fall;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [7:0] amp, input logic [3:0] len,
                            input logic len_err, input logic amp_err, input logic st);
    check({tag, ".valid"},   res_valid,   1'b1);
    check({tag, ".amp"},     res_amp,     amp);
    check({tag, ".len"},     res_len,     len);
    check({tag, ".len_err"}, res_len_err, len_err);
    check({tag, ".amp_err"}, res_amp_err, amp_err);
    check({tag, ".state"},   res_state,   st);
  endtask

  task automatic pop_one();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    pulse_in  = 1'b0;
    amp_in    = 8'h00;
    res_ready = 1'b0;
    thresh    = 8'h80;
    repeat (3) @(negedge clk);
    check("rst.valid",    res_valid,   1'b0);
    check("rst.amp",      res_amp,     8'h00);
    check("rst.len",      res_len,     4'd0);
    check("rst.len_err",  res_len_err, 1'b0);
    check("rst.overflow", overflow,    1'b0);
    check("rst.glitch",   glitch,      1'b0);
    check("rst.drop_cnt", drop_cnt,    8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal 4-cycle pulse; no record before the falling edge has been sampled.
    for (int i = 0; i < 4; i++) begin
      pulse_in = 1'b1;
      amp_in   = 8'h5A;
      @(negedge clk);
    end
    pulse_in = 1'b0;
    amp_in   = 8'h00;
    check("nom.early_valid", res_valid, 1'b0);
    @(negedge clk);
    check_head("nom", 8'h5A, 4'd4, 1'b0, 1'b0, 1'b0);
    pop_one();
    check("nom.popped", res_valid, 1'b0);

    // Amplitude change mid-pulse and wrong length.
    send_pulse(6, 8'h10, 8'h20, 3, 1'b0);
    check_head("ampchg", 8'h10, 4'd6, 1'b1, 1'b1, 1'b0);
    pop_one();

    // Long pulse saturates the length counter.
    send_pulse(20, 8'h33, 8'h33, 0, 1'b0);
    check_head("sat", 8'h33, 4'd15, 1'b1, 1'b0, 1'b0);
    pop_one();

    // Five records into a four-deep FIFO: the last one is dropped.
    for (int k = 1; k <= 5; k++) send_pulse(4, 8'(k), 8'(k), 0, 1'b0);
    check("ovf.overflow", overflow, 1'b1);
    check("ovf.drop_cnt", drop_cnt, 8'd1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovf.order%0d", k), res_amp, 8'(k));
      pop_one();
    end
    check("ovf.empty", res_valid, 1'b0);

    // Full FIFO with push and pop in the same cycle: nothing dropped, order kept.
    for (int k = 1; k <= 4; k++) send_pulse(4, 8'h40 + 8'(k), 8'h00, 0, 1'b0);
    send_pulse(4, 8'h45, 8'h00, 0, 1'b1);
    check("pp.drop_cnt", drop_cnt, 8'd1);
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("pp.order%0d", k), res_amp, 8'h40 + 8'(k));
      pop_one();
    end
    check("pp.empty", res_valid, 1'b0);

    // Reset during a pulse, released while the pulse is still high.
    pulse_in = 1'b1;
    amp_in   = 8'h66;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    pulse_in = 1'b0;
    amp_in   = 8'h00;
    repeat (2) @(negedge clk);
    check("rstmid.valid",    res_valid, 1'b0);
    check("rstmid.drop_cnt", drop_cnt,  8'd0);
    check("rstmid.overflow", overflow,  1'b0);
    send_pulse(4, 8'h77, 8'h77, 0, 1'b0);
    check_head("rstmid.next", 8'h77, 4'd4, 1'b0, 1'b0, 1'b0);
    pop_one();

`ifdef PULSE_RX_THRESH_EN
    send_pulse(4, 8'h7F, 8'h7F, 0, 1'b0);
    send_pulse(4, 8'h80, 8'h80, 0, 1'b0);
    check_head("thr.below", 8'h7F, 4'd4, 1'b0, 1'b0, 1'b0);
    pop_one();
    check_head("thr.at", 8'h80, 4'd4, 1'b0, 1'b0, 1'b1);
    pop_one();
`endif

    // Nonzero amplitude while idle sets the sticky glitch flag.
    check("glitch.before", glitch, 1'b0);
    amp_in = 8'h03;
    @(negedge clk);
    amp_in = 8'h00;
    @(negedge clk);
    check("glitch.after", glitch, 1'b1);
    check("glitch.no_rec", res_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
